// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
// alu_arbiter: round-robin arbiter and sequencer for the shared combinational ALU.
// Two requesters issue ops over valid/ready; registered results return to the owner.
module alu_arbiter #(
   parameter int W   = 8,
   parameter int OPW = 4
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic [1:0]     ReqValid,
   output logic [1:0]     ReqReady,
   input  logic [OPW-1:0] ReqOp0,
   input  logic [OPW-1:0] ReqOp1,
   input  logic [W-1:0]   ReqA0,
   input  logic [W-1:0]   ReqA1,
   input  logic [W-1:0]   ReqB0,
   input  logic [W-1:0]   ReqB1,
   input  logic [2:0]     ReqCtl0,
   input  logic [2:0]     ReqCtl1,
   input  logic [1:0]     ReqLock,
   output logic [1:0]     RspValid,
   input  logic [1:0]     RspReady,
   output logic [W-1:0]   RspOut,
   output logic           RspZero,
   output logic           RspNeg,
   output logic [OPW-1:0] AluOp,
   output logic [W-1:0]   AluA,
   output logic [W-1:0]   AluB,
   output logic [2:0]     AluCtl,
   input  logic [W-1:0]   AluOut,
   input  logic           AluZero,
   input  logic           AluNeg
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]     state_r;
   logic [1:0]     state_nxt_s;
   logic           live_r;
   logic           owner_r;
   logic           ptr_r;
   logic           lock_r;
   logic [OPW-1:0] op_r;
   logic [W-1:0]   a_r;
   logic [W-1:0]   b_r;
   logic [2:0]     ctl_r;
   logic [W-1:0]   out_r;
   logic           zero_r;
   logic           neg_r;
   logic [1:0]     rsp_valid_r;

   logic           grant_s;
   logic           grant_ok_s;
   logic           retire_s;
   logic           hs_s;
   logic [OPW-1:0] sel_op_s;
   logic [W-1:0]   sel_a_s;
   logic [W-1:0]   sel_b_s;
   logic [2:0]     sel_ctl_s;

   // Grant selection: a held lock leaves the owner as the only candidate, even when idle
   always_comb begin
      grant_s    = 1'b0;
      grant_ok_s = 1'b0;
      if (lock_r) begin
         grant_s    = owner_r;
         grant_ok_s = ReqValid[owner_r];
      end else begin
         case (ReqValid)
            2'b01: begin
               grant_s    = 1'b0;
               grant_ok_s = 1'b1;
            end
            2'b10: begin
               grant_s    = 1'b1;
               grant_ok_s = 1'b1;
            end
            2'b11: begin
               grant_s    = ptr_r;
               grant_ok_s = 1'b1;
            end
            default: begin
               grant_s    = 1'b0;
               grant_ok_s = 1'b0;
            end
         endcase
      end
   end

   // live_r is cleared asynchronously so ReqReady drops with reset without reset in the data path
   assign retire_s = (state_r == ST_RESP) && RspReady[owner_r];
   assign hs_s     = live_r && grant_ok_s && ((state_r == ST_IDLE) || retire_s);

   assign sel_op_s  = grant_s ? ReqOp1  : ReqOp0;
   assign sel_a_s   = grant_s ? ReqA1   : ReqA0;
   assign sel_b_s   = grant_s ? ReqB1   : ReqB0;
   assign sel_ctl_s = grant_s ? ReqCtl1 : ReqCtl0;

   // Ready is one-hot on the granted requester whenever an issue slot is open
   always_comb begin
      if (hs_s) begin
         ReqReady = grant_s ? 2'b10 : 2'b01;
      end else begin
         ReqReady = 2'b00;
      end
   end

   // Next state: EXEC always lasts one cycle; RESP waits for the owner's RspReady
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (hs_s) begin
               state_nxt_s = ST_EXEC;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_EXEC: state_nxt_s = ST_RESP;
         ST_RESP: begin
            if (retire_s) begin
               state_nxt_s = hs_s ? ST_EXEC : ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, liveness and arbitration bookkeeping
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_r <= ST_IDLE;
         live_r  <= 1'b0;
         owner_r <= 1'b0;
         ptr_r   <= 1'b0;
         lock_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         live_r  <= 1'b1;
         if (hs_s) begin
            owner_r <= grant_s;
            ptr_r   <= ~grant_s;
            lock_r  <= ReqLock[grant_s];
         end else begin
            owner_r <= owner_r;
            ptr_r   <= ptr_r;
            lock_r  <= lock_r;
         end
      end
   end

   // Operand register drives the ALU only during EXEC; it clears afterwards to present NoOp
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         op_r  <= {OPW{1'b0}};
         a_r   <= {W{1'b0}};
         b_r   <= {W{1'b0}};
         ctl_r <= 3'b000;
      end else if (hs_s) begin
         op_r  <= sel_op_s;
         a_r   <= sel_a_s;
         b_r   <= sel_b_s;
         ctl_r <= sel_ctl_s;
      end else if (state_r == ST_EXEC) begin
         op_r  <= {OPW{1'b0}};
         a_r   <= {W{1'b0}};
         b_r   <= {W{1'b0}};
         ctl_r <= 3'b000;
      end else begin
         op_r  <= op_r;
         a_r   <= a_r;
         b_r   <= b_r;
         ctl_r <= ctl_r;
      end
   end

   // Result register and response valid: captured at the end of EXEC, held until retired
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         out_r       <= {W{1'b0}};
         zero_r      <= 1'b0;
         neg_r       <= 1'b0;
         rsp_valid_r <= 2'b00;
      end else if (state_r == ST_EXEC) begin
         out_r       <= AluOut;
         zero_r      <= AluZero;
         neg_r       <= AluNeg;
         rsp_valid_r <= owner_r ? 2'b10 : 2'b01;
      end else if (retire_s) begin
         out_r       <= out_r;
         zero_r      <= zero_r;
         neg_r       <= neg_r;
         rsp_valid_r <= 2'b00;
      end else begin
         out_r       <= out_r;
         zero_r      <= zero_r;
         neg_r       <= neg_r;
         rsp_valid_r <= rsp_valid_r;
      end
   end

   assign AluOp    = op_r;
   assign AluA     = a_r;
   assign AluB     = b_r;
   assign AluCtl   = ctl_r;
   assign RspValid = rsp_valid_r;
   assign RspOut   = out_r;
   assign RspZero  = zero_r;
   assign RspNeg   = neg_r;

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
// Bench for alu_arbiter: plays both requesters and the combinational ALU, and
// scoreboards every response against hand-computed expected values.
module tb_alu_arbiter;

   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_XOR = 4'd3;
   localparam logic [3:0] OP_LSL = 4'd4;
   localparam logic [3:0] OP_CMP = 4'd5;
   localparam logic [3:0] OP_AND = 4'd6;

   typedef struct {
      logic       req;
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] ctl;
      logic       lock;
      logic [7:0] exp_out;
      logic       exp_zero;
      logic       exp_neg;
   } vec_t;

   logic       Clk;
   logic       Reset;
   logic [1:0] ReqValid;
   logic [1:0] ReqReady;
   logic [3:0] ReqOp0, ReqOp1;
   logic [7:0] ReqA0, ReqA1, ReqB0, ReqB1;
   logic [2:0] ReqCtl0, ReqCtl1;
   logic [1:0] ReqLock;
   logic [1:0] RspValid;
   logic [1:0] RspReady;
   logic [7:0] RspOut;
   logic       RspZero, RspNeg;
   logic [3:0] AluOp;
   logic [7:0] AluA, AluB;
   logic [2:0] AluCtl;
   logic [7:0] AluOut;
   logic       AluZero, AluNeg;
   logic [7:0] alu_res;

   int errors = 0;
   int checks = 0;

   vec_t       pend0[$];
   vec_t       pend1[$];
   vec_t       sb[$];
   bit         grant_log[$];
   vec_t       tbl[6];
   logic [1:0] rsp_rdy;
   logic       exec_pend;
   vec_t       exec_rec;
   logic       hold_pend;
   logic [1:0] hold_valid;
   logic [7:0] hold_out;

   alu_arbiter #(.W(8), .OPW(4)) dut (
      .Clk(Clk), .Reset(Reset),
      .ReqValid(ReqValid), .ReqReady(ReqReady),
      .ReqOp0(ReqOp0), .ReqOp1(ReqOp1),
      .ReqA0(ReqA0), .ReqA1(ReqA1), .ReqB0(ReqB0), .ReqB1(ReqB1),
      .ReqCtl0(ReqCtl0), .ReqCtl1(ReqCtl1), .ReqLock(ReqLock),
      .RspValid(RspValid), .RspReady(RspReady),
      .RspOut(RspOut), .RspZero(RspZero), .RspNeg(RspNeg),
      .AluOp(AluOp), .AluA(AluA), .AluB(AluB), .AluCtl(AluCtl),
      .AluOut(AluOut), .AluZero(AluZero), .AluNeg(AluNeg)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Behavioural stand-in for the shared ALU
   always_comb begin
      case (AluOp)
         OP_ADD:  alu_res = AluA + AluB;
         OP_SUB:  alu_res = AluA - AluB;
         OP_XOR:  alu_res = AluA ^ AluB;
         OP_LSL:  alu_res = AluA << AluB[2:0];
         OP_CMP:  alu_res = AluA - AluB;
         OP_AND:  alu_res = AluA & AluB;
         default: alu_res = 8'h00;
      endcase
   end
   assign AluOut  = alu_res;
   assign AluZero = (alu_res == 8'h00);
   assign AluNeg  = alu_res[7];

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic req, input logic [3:0] op, input logic [7:0] a,
                               input logic [7:0] b, input logic [2:0] ctl, input logic lock,
                               input logic [7:0] exp_out, input logic exp_zero, input logic exp_neg);
      vec_t v;
      v.req = req; v.op = op; v.a = a; v.b = b; v.ctl = ctl; v.lock = lock;
      v.exp_out = exp_out; v.exp_zero = exp_zero; v.exp_neg = exp_neg;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      ReqValid[0] = (pend0.size() != 0);
      ReqValid[1] = (pend1.size() != 0);
      if (pend0.size() != 0) begin
         ReqOp0 = pend0[0].op; ReqA0 = pend0[0].a; ReqB0 = pend0[0].b;
         ReqCtl0 = pend0[0].ctl; ReqLock[0] = pend0[0].lock;
      end else begin
         ReqOp0 = 4'h0; ReqA0 = 8'h00; ReqB0 = 8'h00; ReqCtl0 = 3'd0; ReqLock[0] = 1'b0;
      end
      if (pend1.size() != 0) begin
         ReqOp1 = pend1[0].op; ReqA1 = pend1[0].a; ReqB1 = pend1[0].b;
         ReqCtl1 = pend1[0].ctl; ReqLock[1] = pend1[0].lock;
      end else begin
         ReqOp1 = 4'h0; ReqA1 = 8'h00; ReqB1 = 8'h00; ReqCtl1 = 3'd0; ReqLock[1] = 1'b0;
      end
      RspReady = rsp_rdy;
   endtask

   task automatic accept(input vec_t v);
      sb.push_back(v);
      grant_log.push_back(v.req);
      exec_pend = 1'b1;
      exec_rec  = v;
   endtask

   // One cycle: sample at the falling edge, then update drives just after the rising edge
   task automatic tick();
      vec_t e;
      logic own;
      @(negedge Clk);
      if (exec_pend) begin
         chk("exec_op",  32'(AluOp),  32'(exec_rec.op));
         chk("exec_a",   32'(AluA),   32'(exec_rec.a));
         chk("exec_b",   32'(AluB),   32'(exec_rec.b));
         chk("exec_ctl", 32'(AluCtl), 32'(exec_rec.ctl));
         exec_pend = 1'b0;
      end else if (RspValid == 2'b00) begin
         chk("alu_idle", 32'({AluOp, AluA, AluB, AluCtl}), 32'd0);
      end
      if (hold_pend) begin
         chk("rsp_hold_valid", 32'(RspValid), 32'(hold_valid));
         chk("rsp_hold_out",   32'(RspOut),   32'(hold_out));
         hold_pend = 1'b0;
      end
      if (RspValid != 2'b00) begin
         own = RspValid[1];
         chk("rsp_onehot", 32'(RspValid == 2'b11), 32'd0);
         if (RspReady[own]) begin
            if (sb.size() == 0) begin
               chk("rsp_unexpected", 32'(RspValid), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("rsp_owner", 32'(own),     32'(e.req));
               chk("rsp_out",   32'(RspOut),  32'(e.exp_out));
               chk("rsp_zero",  32'(RspZero), 32'(e.exp_zero));
               chk("rsp_neg",   32'(RspNeg),  32'(e.exp_neg));
            end
         end else begin
            hold_pend  = 1'b1;
            hold_valid = RspValid;
            hold_out   = RspOut;
         end
      end
      chk("req_onehot", 32'(ReqReady == 2'b11), 32'd0);
      if (ReqValid[0] && ReqReady[0] && pend0.size() != 0) accept(pend0.pop_front());
      if (ReqValid[1] && ReqReady[1] && pend1.size() != 0) accept(pend1.pop_front());
      @(posedge Clk);
      #1;
      drive();
   endtask

   task automatic run_until_empty(input int budget);
      int n = 0;
      while ((pend0.size() != 0 || pend1.size() != 0 || sb.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_timeout", 32'(pend0.size() + pend1.size() + sb.size()), 32'd0);
      pend0.delete(); pend1.delete(); sb.delete();
      drive();
   endtask

   initial begin
      int  n;
      bit  exp_lock[3];

      tbl[0] = mk(1'b0, OP_CMP, 8'h02, 8'h05, 3'd3, 1'b0, 8'hFD, 1'b0, 1'b1);
      tbl[1] = mk(1'b0, OP_XOR, 8'h55, 8'h55, 3'd2, 1'b0, 8'h00, 1'b1, 1'b0);
      tbl[2] = mk(1'b1, OP_LSL, 8'h81, 8'h01, 3'd4, 1'b0, 8'h02, 1'b0, 1'b0);
      tbl[3] = mk(1'b1, OP_SUB, 8'h00, 8'h01, 3'd5, 1'b0, 8'hFF, 1'b0, 1'b1);
      tbl[4] = mk(1'b0, OP_ADD, 8'hFF, 8'h02, 3'd6, 1'b0, 8'h01, 1'b0, 1'b0);
      tbl[5] = mk(1'b1, OP_AND, 8'hF0, 8'h0F, 3'd7, 1'b0, 8'h00, 1'b1, 1'b0);
      exp_lock = '{1'b0, 1'b0, 1'b1};

      exec_pend = 1'b0; hold_pend = 1'b0; hold_valid = 2'b00; hold_out = 8'h00;
      rsp_rdy = 2'b11;
      Reset = 1'b0;
      drive();
      repeat (3) @(posedge Clk);
      #1;
      chk("reset_req_ready", 32'(ReqReady), 32'd0);
      chk("reset_rsp_valid", 32'(RspValid), 32'd0);
      chk("reset_rsp", 32'({RspOut, RspZero, RspNeg}), 32'd0);
      chk("reset_alu", 32'({AluOp, AluA, AluB, AluCtl}), 32'd0);
      @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk);
      #1;

      // Contended requests straight after reset: core first, then strict alternation
      pend0.push_back(mk(1'b0, OP_SUB, 8'h05, 8'h03, 3'd1, 1'b0, 8'h02, 1'b0, 1'b0));
      pend0.push_back(mk(1'b0, OP_ADD, 8'h0F, 8'h01, 3'd2, 1'b0, 8'h10, 1'b0, 1'b0));
      pend0.push_back(mk(1'b0, OP_AND, 8'hF0, 8'h3C, 3'd3, 1'b0, 8'h30, 1'b0, 1'b0));
      pend1.push_back(mk(1'b1, OP_XOR, 8'hAA, 8'hFF, 3'd4, 1'b0, 8'h55, 1'b0, 1'b0));
      pend1.push_back(mk(1'b1, OP_SUB, 8'h01, 8'h02, 3'd5, 1'b0, 8'hFF, 1'b0, 1'b1));
      pend1.push_back(mk(1'b1, OP_ADD, 8'h7F, 8'h01, 3'd6, 1'b0, 8'h80, 1'b0, 1'b1));
      drive();
      run_until_empty(60);
      chk("rr_count", 32'(grant_log.size()), 32'd6);
      for (int i = 0; i < grant_log.size(); i++) chk("rr_order", 32'(grant_log[i]), 32'(i % 2));

      // Lock: the CMP owner keeps the ALU through its next op even while idle
      grant_log.delete();
      pend0.push_back(mk(1'b0, OP_CMP, 8'h03, 8'h03, 3'd1, 1'b1, 8'h00, 1'b1, 1'b0));
      pend1.push_back(mk(1'b1, OP_XOR, 8'h0F, 8'h0F, 3'd2, 1'b0, 8'h00, 1'b1, 1'b0));
      drive();
      n = 0;
      while ((sb.size() != 0 || pend0.size() != 0 || exec_pend) && n < 20) begin
         tick();
         n++;
      end
      repeat (3) tick();
      chk("lock_aux_blocked", 32'(grant_log.size()), 32'd1);
      chk("lock_aux_pending", 32'(pend1.size()), 32'd1);
      pend0.push_back(mk(1'b0, OP_LSL, 8'h01, 8'h03, 3'd0, 1'b0, 8'h08, 1'b0, 1'b0));
      drive();
      run_until_empty(20);
      chk("lock_count", 32'(grant_log.size()), 32'd3);
      for (int i = 0; i < grant_log.size() && i < 3; i++)
         chk("lock_order", 32'(grant_log[i]), 32'(exp_lock[i]));

      // Single op latency
      pend0.push_back(mk(1'b0, OP_ADD, 8'h0F, 8'h01, 3'd1, 1'b0, 8'h10, 1'b0, 1'b0));
      drive();
      #1;
      chk("single_ready", 32'(ReqReady), 32'd1);
      tick();
      tick();
      chk("single_rsp_valid", 32'(RspValid), 32'd1);
      chk("single_rsp_out", 32'(RspOut), 32'h10);
      run_until_empty(10);

      // Backpressure on aux; the core's RspReady must not retire it
      grant_log.delete();
      rsp_rdy = 2'b01;
      pend1.push_back(mk(1'b1, OP_ADD, 8'h80, 8'h80, 3'd2, 1'b0, 8'h00, 1'b1, 1'b0));
      drive();
      n = 0;
      while (RspValid == 2'b00 && n < 10) begin
         tick();
         n++;
      end
      chk("bp_rsp_valid", 32'(RspValid), 32'd2);
      pend0.push_back(mk(1'b0, OP_ADD, 8'h01, 8'h01, 3'd3, 1'b0, 8'h02, 1'b0, 1'b0));
      drive();
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valid_stable", 32'(RspValid), 32'd2);
         chk("bp_out_stable", 32'(RspOut), 32'h00);
         chk("bp_no_grant", 32'(ReqReady), 32'd0);
      end
      chk("bp_grant_count", 32'(grant_log.size()), 32'd1);
      rsp_rdy = 2'b11;
      drive();
      #1;
      chk("bp_b2b_ready", 32'(ReqReady), 32'd1);
      tick();
      chk("bp_b2b_exec_op", 32'(AluOp), 32'(OP_ADD));
      chk("bp_b2b_rsp_clear", 32'(RspValid), 32'd0);
      run_until_empty(20);

      // Table-driven single ops
      for (int i = 0; i < 6; i++) begin
         if (tbl[i].req) pend1.push_back(tbl[i]);
         else            pend0.push_back(tbl[i]);
         drive();
         run_until_empty(20);
         chk("tbl_grant", 32'(grant_log[$]), 32'(tbl[i].req));
      end

      // Reset asserted while an op sits in EXEC
      pend0.push_back(mk(1'b0, OP_ADD, 8'h0F, 8'h01, 3'd5, 1'b0, 8'h10, 1'b0, 1'b0));
      drive();
      tick();
      #1;
      Reset = 1'b0;
      sb.delete(); exec_pend = 1'b0; hold_pend = 1'b0;
      pend0.push_back(mk(1'b0, OP_SUB, 8'h09, 8'h04, 3'd1, 1'b0, 8'h05, 1'b0, 1'b0));
      pend1.push_back(mk(1'b1, OP_XOR, 8'h0F, 8'hF0, 3'd2, 1'b0, 8'hFF, 1'b0, 1'b1));
      drive();
      #1;
      chk("mid_reset_req_ready", 32'(ReqReady), 32'd0);
      chk("mid_reset_rsp_valid", 32'(RspValid), 32'd0);
      chk("mid_reset_rsp", 32'({RspOut, RspZero, RspNeg}), 32'd0);
      chk("mid_reset_alu", 32'({AluOp, AluA, AluB, AluCtl}), 32'd0);
      repeat (2) tick();
      #2;
      Reset = 1'b1;
      grant_log.delete();
      run_until_empty(30);
      chk("post_reset_count", 32'(grant_log.size()), 32'd2);
      chk("post_reset_first", 32'(grant_log[0]), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
